// File: rtl/batalla_pkg.sv
// Shared types and constants for the 5x5 battleship shot sequencer.
package batalla_pkg;

    localparam int NUM_CELLS = 25;

    typedef logic [2:0] estado_t;

    localparam estado_t IDLE   = 3'd0;
    localparam estado_t INIT   = 3'd1;
    localparam estado_t WAIT   = 3'd2;
    localparam estado_t FIRE   = 3'd3;
    localparam estado_t EVAL   = 3'd4;
    localparam estado_t REPORT = 3'd5;
    localparam estado_t OVER   = 3'd6;

    typedef logic [4:0] fila_t;
    typedef fila_t matriz_t [4:0];

endpackage

// File: rtl/contador_turno.sv
// Player idle-time counter: counts cycles spent waiting and flags when the
// auto-shooter may take over. Saturates so a long idle never wraps back.
module contador_turno #(
    parameter int TIMEOUT = 1000,
    parameter int TW      = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam logic [TW-1:0] LIMITE = TW'(TIMEOUT);

    logic [TW-1:0] cuenta_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cuenta_q <= '0;
        end else if (clear) begin
            cuenta_q <= '0;
        end else if (inc && (cuenta_q != '1)) begin
            cuenta_q <= cuenta_q + 1'b1;
        end
    end

    assign expired = (cuenta_q >= LIMITE);

endmodule

// File: rtl/control_disparos.sv
// Shot sequencer/arbiter: initialises the fleet, arbitrates player/auto shots,
// rejects bad cells, strobes the fleet register and classifies each result.
module control_disparos
    import batalla_pkg::*;
#(
    parameter int NUM_BARCOS = 5,
    parameter int TIMEOUT    = 1000,
    parameter int TW         = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       req_jug,
    input  logic [4:0] casilla_jug,
    input  logic       req_auto,
    input  logic [4:0] casilla_auto,
    input  matriz_t    barcos_in,
    output logic       setter,
    output logic       enable,
    output logic [4:0] casilla,
    output logic       ack_jug,
    output logic       ack_auto,
    output logic       invalido,
    output logic       res_valid,
    output logic       acierto,
    output logic       hundido,
    output logic [2:0] id_hundido,
    output logic       victoria,
    output logic [6:0] disparos
);

    estado_t              estado_q, estado_d;
    logic [4:0]           celda_q;
    logic [NUM_CELLS-1:0] mapa_q;
    matriz_t              snap_q;
    logic                 ack_jug_q, ack_auto_q, invalido_q;
    logic                 acierto_q, hundido_q, victoria_q;
    logic [2:0]           id_q;
    logic [6:0]           disparos_q;

    logic                 expirado;
    logic                 ack_pend, grant_jug, grant_auto, grant;
    logic [4:0]           celda_sel;
    logic [NUM_CELLS-1:0] bit_sel;
    logic                 fuera, repetida, aceptar;
    logic                 acierto_c, victoria_c;
    logic [3:0]           hund_c;

    // Lowest-index ship that was alive in the snapshot and is now all zero.
    function automatic logic [3:0] buscar_hundido(input matriz_t antes, input matriz_t ahora);
        logic [3:0] r;
        r = '0;
        for (int i = 4; i >= 0; i--) begin
            if (i < NUM_BARCOS && antes[i] != '0 && ahora[i] == '0) begin
                r = {1'b1, 3'(i)};
            end
        end
        return r;
    endfunction

    // Block re-grant during the ack cycle: the requester only drops req after seeing ack.
    assign ack_pend   = ack_jug_q | ack_auto_q;
    assign grant_jug  = (estado_q == WAIT) && req_jug && !ack_pend;
    assign grant_auto = (estado_q == WAIT) && req_auto && !req_jug && expirado && !ack_pend;
    assign grant      = grant_jug | grant_auto;
    assign celda_sel  = grant_jug ? casilla_jug : casilla_auto;
    assign bit_sel    = NUM_CELLS'(1) << celda_sel;
    assign fuera      = (celda_sel > 5'd24);
    assign repetida   = |(mapa_q & bit_sel);
    assign aceptar    = grant && !fuera && !repetida;

    always_comb begin
        acierto_c  = 1'b0;
        victoria_c = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i < NUM_BARCOS) begin
                if ((snap_q[i] & ~barcos_in[i]) != '0) acierto_c = 1'b1;
                if (barcos_in[i] != '0) victoria_c = 1'b0;
            end
        end
        hund_c = buscar_hundido(snap_q, barcos_in);
    end

    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            IDLE:    if (start) estado_d = INIT;
            INIT:    estado_d = WAIT;
            WAIT:    if (aceptar) estado_d = FIRE;
            FIRE:    estado_d = EVAL;
            EVAL:    estado_d = REPORT;
            REPORT:  estado_d = victoria_q ? OVER : WAIT;
            OVER:    if (start) estado_d = INIT;
            default: estado_d = IDLE;
        endcase
    end

    contador_turno #(
        .TIMEOUT (TIMEOUT),
        .TW      (TW)
    ) u_contador (
        .clk     (clk),
        .rst     (rst),
        .clear   ((estado_q == INIT) || (estado_d == WAIT && estado_q != WAIT)),
        .inc     (estado_q == WAIT),
        .expired (expirado)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            estado_q   <= IDLE;
            celda_q    <= '0;
            mapa_q     <= '0;
            snap_q     <= '{default: '0};
            ack_jug_q  <= 1'b0;
            ack_auto_q <= 1'b0;
            invalido_q <= 1'b0;
            acierto_q  <= 1'b0;
            hundido_q  <= 1'b0;
            id_q       <= '0;
            victoria_q <= 1'b0;
            disparos_q <= '0;
        end else begin
            estado_q   <= estado_d;
            ack_jug_q  <= grant_jug;
            ack_auto_q <= grant_auto;
            invalido_q <= grant && !aceptar;
            if (aceptar) begin
                celda_q <= celda_sel;
                mapa_q  <= mapa_q | bit_sel;
                snap_q  <= barcos_in;
            end
            if (estado_q == INIT) begin
                mapa_q     <= '0;
                disparos_q <= '0;
                acierto_q  <= 1'b0;
                hundido_q  <= 1'b0;
                id_q       <= '0;
                victoria_q <= 1'b0;
            end
            // Results are registered on the way into REPORT so they show with res_valid.
            if (estado_q == EVAL) begin
                acierto_q  <= acierto_c;
                hundido_q  <= hund_c[3];
                id_q       <= hund_c[2:0];
                victoria_q <= victoria_c;
                if (disparos_q != 7'd127) disparos_q <= disparos_q + 7'd1;
            end
        end
    end

    assign setter     = (estado_q == INIT);
    assign enable     = (estado_q == FIRE);
    assign res_valid  = (estado_q == REPORT);
    assign casilla    = (estado_q == FIRE || estado_q == EVAL || estado_q == REPORT) ? celda_q : '0;
    assign ack_jug    = ack_jug_q;
    assign ack_auto   = ack_auto_q;
    assign invalido   = invalido_q;
    assign acierto    = acierto_q;
    assign hundido    = hundido_q;
    assign id_hundido = id_q;
    assign victoria   = victoria_q;
    assign disparos   = disparos_q;

endmodule

// File: tb/tb_control_disparos.sv
// Scoreboard bench for control_disparos with a behavioural fleet register
// (ship i occupies cells 5*i .. 5*i+i).
module tb_control_disparos;
    import batalla_pkg::*;

    localparam int TO = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       req_jug = 1'b0;
    logic [4:0] casilla_jug = '0;
    logic       req_auto = 1'b0;
    logic [4:0] casilla_auto = '0;
    matriz_t    barcos = '{default: '0};
    logic       setter, enable, ack_jug, ack_auto, invalido, res_valid;
    logic       acierto, hundido, victoria;
    logic [4:0] casilla;
    logic [2:0] id_hundido;
    logic [6:0] disparos;

    control_disparos #(
        .NUM_BARCOS (5),
        .TIMEOUT    (TO),
        .TW         (5)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .req_jug      (req_jug),
        .casilla_jug  (casilla_jug),
        .req_auto     (req_auto),
        .casilla_auto (casilla_auto),
        .barcos_in    (barcos),
        .setter       (setter),
        .enable       (enable),
        .casilla      (casilla),
        .ack_jug      (ack_jug),
        .ack_auto     (ack_auto),
        .invalido     (invalido),
        .res_valid    (res_valid),
        .acierto      (acierto),
        .hundido      (hundido),
        .id_hundido   (id_hundido),
        .victoria     (victoria),
        .disparos     (disparos)
    );

    always #5 clk = ~clk;

    // Fleet register model.
    always @(posedge clk) begin
        if (setter) begin
            for (int i = 0; i < 5; i++)
                for (int j = 0; j < 5; j++)
                    barcos[i][j] <= (j <= i);
        end else if (enable && casilla < 5'd25) begin
            barcos[casilla / 5][casilla % 5] <= 1'b0;
        end
    end

    typedef struct packed {logic jug; logic inv;} ack_t;
    typedef struct packed {logic a; logic h; logic [2:0] id; logic [6:0] d; logic v;} res_t;

    ack_t       ack_q[$];
    logic [4:0] en_q[$];
    res_t       res_q[$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         ack_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents an ack, enable or result.
    always @(negedge clk) begin
        ack_t e;
        res_t r;
        logic [4:0] c;
        cyc++;
        if (ack_jug || ack_auto) begin
            if (ack_q.size() == 0) begin
                check("unexpected_ack", {ack_jug, ack_auto}, 0);
            end else begin
                e = ack_q.pop_front();
                check("ack", {ack_jug, ack_auto, invalido}, {e.jug, !e.jug, e.inv});
                if (!invalido) ack_cyc = cyc;
            end
        end
        if (enable) begin
            if (en_q.size() == 0) begin
                check("unexpected_enable", casilla, 0);
            end else begin
                c = en_q.pop_front();
                check("enable_casilla", casilla, c);
            end
        end
        if (res_valid) begin
            if (res_q.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                r = res_q.pop_front();
                check("result", {acierto, hundido, id_hundido, disparos, victoria}, r);
                check("ack_to_result_latency", cyc - ack_cyc, 2);
            end
        end
    end

    task automatic exp_ack(input logic jug, input logic inv);
        ack_q.push_back('{jug: jug, inv: inv});
    endtask

    task automatic exp_res(input logic [4:0] c, input logic a, input logic h,
                           input logic [2:0] id, input logic [6:0] d, input logic v);
        en_q.push_back(c);
        res_q.push_back('{a: a, h: h, id: id, d: d, v: v});
    endtask

    task automatic wait_sig(input int which, input string name);
        bit seen;
        seen = 0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk);
            case (which)
                0:       seen = ack_jug;
                1:       seen = ack_auto;
                default: seen = res_valid;
            endcase
        end
        if (!seen) check(name, 0, 1);
    endtask

    task automatic shot_jug(input logic [4:0] c, input logic inv);
        casilla_jug = c;
        req_jug = 1'b1;
        wait_sig(0, "timeout_ack_jug");
        req_jug = 1'b0;
        if (!inv) wait_sig(2, "timeout_res_valid");
    endtask

    task automatic fire(input logic [4:0] c, input logic a, input logic h,
                        input logic [2:0] id, input logic [6:0] d, input logic v);
        exp_ack(1'b1, 1'b0);
        exp_res(c, a, h, id, d, v);
        shot_jug(c, 1'b0);
    endtask

    task automatic reject(input logic [4:0] c);
        exp_ack(1'b1, 1'b1);
        shot_jug(c, 1'b1);
    endtask

    task automatic do_start(input string name);
        start = 1'b1;
        @(negedge clk);
        check({name, "_setter_high"}, setter, 1);
        start = 1'b0;
        @(negedge clk);
        check({name, "_setter_one_cycle"}, setter, 0);
        check({name, "_cleared"}, {victoria, acierto, hundido, disparos}, 0);
    endtask

    task automatic count_acks(input int n, input string name);
        int acks;
        acks = 0;
        repeat (n) begin
            @(negedge clk);
            if (ack_jug || ack_auto) acks++;
        end
        check(name, acks, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset_outputs", {setter, enable, casilla, ack_jug, ack_auto, invalido, res_valid,
                                acierto, hundido, id_hundido, victoria, disparos}, 0);
        rst = 1'b1;
        @(negedge clk);
        do_start("start1");

        fire(5'd12, 1, 0, 3'd0, 7'd1, 0);
        reject(5'd25);
        reject(5'd12);
        fire(5'd0, 1, 1, 3'd0, 7'd2, 0);
        fire(5'd3, 0, 0, 3'd0, 7'd3, 0);

        // Auto-shooter ignored until the player has idled TIMEOUT cycles.
        casilla_auto = 5'd5;
        req_auto = 1'b1;
        count_acks(10, "auto_before_timeout");
        exp_ack(1'b0, 1'b0);
        exp_res(5'd5, 1, 0, 3'd0, 7'd4, 0);
        wait_sig(1, "timeout_ack_auto");
        req_auto = 1'b0;
        wait_sig(2, "timeout_res_valid");

        // Both requests after timeout: player first, auto served on the next timeout.
        repeat (TO + 5) @(negedge clk);
        casilla_jug = 5'd6;
        casilla_auto = 5'd10;
        req_jug = 1'b1;
        req_auto = 1'b1;
        exp_ack(1'b1, 1'b0);
        exp_res(5'd6, 1, 1, 3'd1, 7'd5, 0);
        wait_sig(0, "timeout_ack_jug");
        req_jug = 1'b0;
        wait_sig(2, "timeout_res_valid");
        exp_ack(1'b0, 1'b0);
        exp_res(5'd10, 1, 0, 3'd0, 7'd6, 0);
        wait_sig(1, "timeout_ack_auto");
        req_auto = 1'b0;
        wait_sig(2, "timeout_res_valid");

        fire(5'd11, 1, 1, 3'd2, 7'd7, 0);
        for (int i = 15; i < 18; i++) fire(5'(i), 1, 0, 3'd0, 7'(i - 7), 0);
        fire(5'd18, 1, 1, 3'd3, 7'd11, 0);
        for (int i = 20; i < 24; i++) fire(5'(i), 1, 0, 3'd0, 7'(i - 8), 0);
        fire(5'd24, 1, 1, 3'd4, 7'd16, 1);

        @(negedge clk);
        check("victoria_held", victoria, 1);
        casilla_jug = 5'd1;
        req_jug = 1'b1;
        count_acks(10, "no_ack_in_over");
        req_jug = 1'b0;
        check("victoria_still_held", victoria, 1);

        do_start("restart");
        fire(5'd20, 1, 0, 3'd0, 7'd1, 0);

        // Reset while the shot is in FIRE.
        exp_ack(1'b1, 1'b0);
        en_q.push_back(5'd21);
        casilla_jug = 5'd21;
        req_jug = 1'b1;
        wait_sig(0, "timeout_ack_jug");
        req_jug = 1'b0;
        #1 rst = 1'b0;
        #1;
        check("reset_in_fire", {setter, enable, casilla, ack_jug, ack_auto, invalido, res_valid,
                                acierto, hundido, id_hundido, victoria, disparos}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        casilla_jug = 5'd7;
        req_jug = 1'b1;
        count_acks(5, "idle_after_reset");
        req_jug = 1'b0;
        do_start("start_after_reset");
        fire(5'd24, 1, 0, 3'd0, 7'd1, 0);

        repeat (3) @(negedge clk);
        check("queues_drained", ack_q.size() + en_q.size() + res_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
